// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and constants for the two-source round-robin mux arbiter.
// Imported by the arbiter top and by the saturating counter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_t;

    localparam logic SEL_SRC0 = 1'b0;
    localparam logic SEL_SRC1 = 1'b1;

    localparam int             CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Source request/data, downstream valid/ready and grant signals of the arbiter.
// master = arbiter side, slave = sources plus downstream stage.
interface mux2_rr_arbiter_if #(parameter int W = 1);

    logic         req0;
    logic         req1;
    logic [W-1:0] data0;
    logic [W-1:0] data1;
    logic         out_ready;
    logic         out_valid;
    logic         sel;
    logic [W-1:0] out_data;
    logic         grant0;
    logic         grant1;

    modport master (
        input  req0, req1, data0, data1, out_ready,
        output out_valid, sel, out_data, grant0, grant1
    );

    modport slave (
        output req0, req1, data0, data1, out_ready,
        input  out_valid, sel, out_data, grant0, grant1
    );

endinterface

// File: rtl/mux2_rr_arbiter_sat_counter.sv
// Up-counter that sticks at its all-ones value; one increment per cycle with inc high.
// Latency: count reflects an increment after the following rising edge.
module sat_counter
    import mux2_arb_pkg::*;
#(
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CW{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for two sources feeding a 2:1 mux; winner's data and sel are
// registered on grant entry (1-cycle req->valid), held stable while out_ready is low,
// and released with a combinational grant pulse on accept.
// MUX2_ARB_CNT_EN adds per-source saturating accepted-transfer counters cnt0/cnt1.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int W = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mux2_rr_arbiter_if.master  bus
`ifdef MUX2_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0]   cnt0,
    output logic [CNT_W-1:0]   cnt1
`endif
);

    arb_state_t   state_q, state_d;
    logic [W-1:0] data_q;
    logic         sel_q;
    logic         last_q;
    logic         accept;
    logic         load0, load1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state: an accept hands straight over to a waiting opposite source
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1)
                    state_d = last_q ? G0 : G1;
                else if (bus.req0)
                    state_d = G0;
                else if (bus.req1)
                    state_d = G1;
            end
            G0: if (bus.out_ready) state_d = bus.req1 ? G1 : IDLE;
            G1: if (bus.out_ready) state_d = bus.req0 ? G0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.out_valid = (state_q != IDLE);
        bus.sel       = sel_q;
        bus.out_data  = data_q;
        bus.grant0    = bus.out_valid && bus.out_ready && (sel_q == SEL_SRC0);
        bus.grant1    = bus.out_valid && bus.out_ready && (sel_q == SEL_SRC1);
    end

    assign accept = (state_q != IDLE) && bus.out_ready;
    assign load0  = (state_d == G0) && (state_q != G0);
    assign load1  = (state_d == G1) && (state_q != G1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            sel_q  <= SEL_SRC0;
            last_q <= 1'b1;
        end else begin
            if (load0) begin
                data_q <= bus.data0;
                sel_q  <= SEL_SRC0;
            end else if (load1) begin
                data_q <= bus.data1;
                sel_q  <= SEL_SRC1;
            end
            if (accept)
                last_q <= sel_q;
        end
    end

`ifdef MUX2_ARB_CNT_EN
    sat_counter #(.CW(CNT_W)) u_cnt0 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.grant0),
        .count (cnt0)
    );

    sat_counter #(.CW(CNT_W)) u_cnt1 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.grant1),
        .count (cnt1)
    );
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter; counter checks only when MUX2_ARB_CNT_EN is defined.
module tb_mux2_rr_arbiter;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    int   n_gr;

    mux2_rr_arbiter_if #(.W(8)) bus ();

`ifdef MUX2_ARB_CNT_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;
`endif

    mux2_rr_arbiter #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
`ifdef MUX2_ARB_CNT_EN
        ,
        .cnt0  (cnt0),
        .cnt1  (cnt1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        n_gr     = 0;
        rst_n         = 1'b0;
        bus.req0      = 1'b0;
        bus.req1      = 1'b0;
        bus.data0     = 8'h00;
        bus.data1     = 8'h00;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_sel",   bus.sel,       0);
        chk("rst_data",  bus.out_data,  0);
        chk("rst_gr0",   bus.grant0,    0);
        chk("rst_gr1",   bus.grant1,    0);

        // single source 0 transfer
        @(negedge clk);
        rst_n         = 1'b1;
        bus.req0      = 1'b1;
        bus.data0     = 8'h01;
        bus.out_ready = 1'b1;
        tick();
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_sel",   bus.sel,       0);
        chk("t1_data",  bus.out_data,  8'h01);
        chk("t1_gr0",   bus.grant0,    1);
        chk("t1_gr1",   bus.grant1,    0);
        bus.req0 = 1'b0;
        tick();
        chk("t1_idle_valid", bus.out_valid, 0);
        chk("t1_idle_gr0",   bus.grant0,    0);

        // both requesting after reset: alternate 0,1,0,1
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.data0 = 8'hA5;
        bus.data1 = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alt_sel",  bus.sel,      i % 2);
            chk("alt_gr0",  bus.grant0,   (i % 2) == 0);
            chk("alt_gr1",  bus.grant1,   (i % 2) == 1);
            chk("alt_data", bus.out_data, (i % 2) ? 8'h3C : 8'hA5);
        end

        // G1 stalled 5 cycles while data1 toggles
        bus.out_ready = 1'b0;
        bus.req0      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.data1 = ~bus.data1;
            tick();
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_sel",   bus.sel,       1);
            chk("stall_data",  bus.out_data,  8'h3C);
            chk("stall_gr1",   bus.grant1,    0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("stall_rel_gr1", bus.grant1, 1);
        chk("stall_rel_gr0", bus.grant0, 0);
        bus.req1 = 1'b0;
        tick();
        chk("stall_end_valid", bus.out_valid, 0);
        chk("stall_end_gr1",   bus.grant1,    0);

        // single source 1: grant every second cycle
        bus.req1  = 1'b1;
        bus.data1 = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("solo1_gr1",   bus.grant1,    (i % 2) == 0);
            chk("solo1_valid", bus.out_valid, (i % 2) == 0);
            chk("solo1_gr0",   bus.grant0,    0);
        end
        bus.req1 = 1'b0;

        // reset asserted in G0 mid-transfer
        bus.req0  = 1'b1;
        bus.data0 = 8'hC3;
        tick();
        chk("mid_valid", bus.out_valid, 1);
        chk("mid_data",  bus.out_data,  8'hC3);
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_gr0",   bus.grant0,    0);
        chk("mid_rst_data",  bus.out_data,  0);
        bus.req1      = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_sel",  bus.sel,      0);
        chk("post_rst_gr0",  bus.grant0,   1);
        chk("post_rst_data", bus.out_data, 8'hC3);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        chk("post_rst_idle", bus.out_valid, 0);

`ifdef MUX2_ARB_CNT_EN
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        chk("cnt0_rst", cnt0, 0);
        chk("cnt1_rst", cnt1, 0);
        bus.req0 = 1'b1;
        for (int c = 0; c < 1000 && n_gr < 300; c++) begin
            tick();
            if (bus.grant0) n_gr++;
        end
        bus.req0 = 1'b0;
        tick();
        tick();
        chk("cnt_grants", n_gr, 300);
        chk("cnt0_sat",   cnt0, 8'd255);
        chk("cnt1_zero",  cnt1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Two-source round-robin arbiter that sits directly upstream of the 2:1 select mux and drives its select line. It accepts requests from two sources and grants one at a time. It registers the winning source's data together with a stable `sel`, then presents both to the downstream stage under a valid/ready handshake. The source is released with a one-cycle grant pulse only when the transfer is accepted.

## Interface
- `W`, default 1: width of each data input and of `out_data`.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0` input 1: source 0 request. Held high until `grant0` is seen.
- `req1` input 1: source 1 request. Held high until `grant1` is seen.
- `data0` input W: source 0 payload. Routed when `sel`=0.
- `data1` input W: source 1 payload. Routed when `sel`=1.
- `out_ready` input 1: downstream can accept.
- `out_valid` output 1: `out_data`/`sel` hold a transfer.
- `sel` output 1: mux select. 0 selects source 0, 1 selects source 1.
- `out_data` output W: registered payload of the granted source.
- `grant0` output 1: combinational pulse when a source-0 transfer is accepted.
- `grant1` output 1: combinational pulse when a source-1 transfer is accepted.

## Operation
- FSM states: IDLE, G0, G1 (2-bit encoding).
- Reset values: state=IDLE, `out_valid`=0, `sel`=0, `out_data`=0, `last`=1. `last` is the last-granted pointer, so source 0 wins first.
- IDLE transitions:
  - `req0` only: go to G0.
  - `req1` only: go to G1.
  - Both requesting: go to the source ≠ `last`.
  - Neither requesting: stay in IDLE.
- On entering Gx:
  - `out_data` ← `datax`, `sel` ← x, `out_valid` ← 1.
  - Data is captured once on entry. Later changes on `datax` are ignored until the transfer is accepted.
- In Gx with `out_ready`=0: hold state. `out_valid`, `sel` and `out_data` stay stable.
- In Gx with `out_ready`=1 (accept):
  - `grantx`=1 in that cycle.
  - `last` ← x.
  - If the other source is requesting, go directly to its G state (back-to-back, no bubble) and load its data.
  - Otherwise go to IDLE with `out_valid` ← 0.
- The same source is never granted back-to-back. Its `req` is still high in the accept cycle, so at least one IDLE cycle separates two grants to one source.
- `grant0`/`grant1` equal `out_valid & out_ready & (sel==x)`. They are never both high.
- Requests that drop before being granted are simply not served. There is no latching of requests.

## Timing
- Request-to-valid latency: `req` seen high at edge N (IDLE) gives `out_valid`=1 after edge N.
- Accept occurs at the edge where `out_valid`&`out_ready`. The grant pulse is visible in the cycle before that edge.
- Throughput:
  - Alternating sources: 1 transfer/cycle.
  - Single source: 1 transfer per 2 cycles.
- Reset asserted mid-transfer: `out_valid` clears immediately (asynchronously). The pending transfer is discarded and no grant is issued. After reset release, arbitration restarts with source 0 priority.

## Configuration
- `MUX2_ARB_CNT_EN` defined:
  - Adds outputs `cnt0` and `cnt1` (8 bits each). They count accepted transfers per source.
  - The counters saturate at 255 and reset to 0.
- `MUX2_ARB_CNT_EN` not defined: the ports and the counter logic are absent. Arbitration behaviour is identical either way.

## Structure
- Package `mux2_arb_pkg`:
  - State enum type `arb_state_t` (IDLE, G0, G1).
  - Constants `SEL_SRC0`=0 and `SEL_SRC1`=1.
  - `CNT_W`=8 and `CNT_MAX`=255.
- One sub-module, `sat_counter`, instantiated twice under the macro. Its ports are `clk`, `rst_n`, `inc`, `count`, and it is parameterised by `CNT_W`.
- The FSM, data register and grant logic stay in the top module.

## Test plan
- Reset, then `req0`=1 with `data0`=1 and `out_ready`=1 → `out_valid`=1, `sel`=0, `out_data`=1 after one edge. `grant0` pulses for one cycle, then state returns to IDLE.
- `req0`=`req1`=1 together after reset, with `out_ready`=1 → grants alternate 0,1,0,1 on consecutive cycles and `sel` toggles each cycle.
- G1 with `out_ready`=0 for 5 cycles while `data1` toggles → `out_data` and `sel`=1 stay stable and there is no grant. Raising `out_ready` gives a single `grant1`.
- Only `req1` is held high with `out_ready`=1 → `grant1` every second cycle, with an IDLE cycle in between.
- Assert `rst_n`=0 mid-transfer in G0 → `out_valid`=0 immediately and no `grant0`. After release, source 0 wins a tie.
- With `MUX2_ARB_CNT_EN` defined, 300 accepted source-0 transfers → `cnt0`=255 (saturated) and `cnt1`=0.
